// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache.
// Hits answer combinationally; misses run one fill on iREN/iaddr/iwait/iload.
// Ports:
//   CLK, nRST         clock, synchronous active-low reset
//   imemREN, imemaddr fetch request from the datapath
//   ihit, imemload    hit flag and instruction word (0 when no hit)
//   iREN, iaddr       memory read request and word-aligned address
//   iwait, iload      memory busy flag and read data
//   flush             invalidate every line at the next edge
//   miss_count        saturating count of misses taken
module icache #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   input  logic        flush,
   output logic [15:0] miss_count
);
   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t state, next_state;

   logic [SETS-1:0] valid;
   logic [TW-1:0]   tag_arr  [SETS];
   logic [31:0]     data_arr [SETS];

   // Only the word address of the missing fetch is kept.
   logic [29:0]     miss_addr;
   logic [15:0]     miss_cnt;

   logic [IW-1:0]   req_idx, miss_idx;
   logic [TW-1:0]   req_tag, miss_tag;
   logic            hit, miss_start, fill_done;
   logic            unused_offset;

   assign req_idx  = imemaddr[IW+1:2];
   assign req_tag  = imemaddr[31:IW+2];
   assign miss_idx = miss_addr[IW-1:0];
   assign miss_tag = miss_addr[29:IW];

   assign unused_offset = ^imemaddr[1:0];

   assign hit = imemREN && (state == IDLE) && valid[req_idx]
             && (tag_arr[req_idx] == req_tag);
   assign miss_start = (state == IDLE) && imemREN && !hit;
   assign fill_done  = (state == FETCH) && !iwait;

   assign iaddr      = {miss_addr, 2'b00};
   assign miss_count = miss_cnt;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (miss_start) next_state = FETCH;
         FETCH:   if (!iwait)     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      case (state)
         IDLE: begin
            ihit     = hit;
            imemload = hit ? data_arr[req_idx] : '0;
         end
         FETCH:   iREN = 1'b1;
         default: iREN = 1'b0;
      endcase
   end

   // Flush beats a same-edge fill: the line is written but left invalid.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         valid     <= '0;
         miss_addr <= '0;
         miss_cnt  <= '0;
      end else begin
         if (miss_start) begin
            miss_addr <= imemaddr[31:2];
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
         end
         if (flush)          valid           <= '0;
         else if (fill_done) valid[miss_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST && fill_done) begin
         data_arr[miss_idx] <= iload;
         tag_arr[miss_idx]  <= miss_tag;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (SETS=16).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_icache;
   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        flush;
   logic [15:0] miss_count;

   int vectors    = 0;
   int miscompares = 0;

   icache #(.SETS(16)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .imemREN   (imemREN),
      .imemaddr  (imemaddr),
      .ihit      (ihit),
      .imemload  (imemload),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iwait     (iwait),
      .iload     (iload),
      .flush     (flush),
      .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   // Stimulus only: miss on addr and fill it with zero wait states.
   task automatic fill_line(input logic [31:0] a, input logic [31:0] d);
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iload = d;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0;
      iwait = 1'b1; iload = 32'h0; flush = 1'b0;
      @(posedge CLK);
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK); #1;
         vectors++;
         if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0
             || miss_count !== 16'h0 || imemload !== 32'h0) begin
            miscompares++;
            $display("FAIL reset c%0d: ihit=%b iREN=%b iaddr=%h cnt=%h load=%h want 0",
                     c, ihit, iREN, iaddr, miss_count, imemload);
         end
      end
      @(negedge CLK);
      nRST = 1'b1; imemREN = 1'b0;
   endtask

   task automatic test_cold_miss;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1; iload = 32'h8C220000;
      #1; vectors++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
         miscompares++;
         $display("FAIL cold_detect: ihit=%b iREN=%b want 0 0", ihit, iREN);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         iwait = (k == 3) ? 1'b0 : 1'b1;
         #1; vectors++;
         if (iREN !== 1'b1 || iaddr !== 32'h4 || ihit !== 1'b0
             || miss_count !== 16'd1) begin
            miscompares++;
            $display("FAIL cold_fetch k%0d: iREN=%b iaddr=%h ihit=%b cnt=%0d want 1 4 0 1",
                     k, iREN, iaddr, ihit, miss_count);
         end
      end
      @(negedge CLK);
      iwait = 1'b1;
      #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h8C220000 || iREN !== 1'b0
          || miss_count !== 16'd1) begin
         miscompares++;
         $display("FAIL cold_hit: ihit=%b load=%h iREN=%b cnt=%0d want 1 8c220000 0 1",
                  ihit, imemload, iREN, miss_count);
      end
   endtask

   task automatic test_conflict;
      @(negedge CLK);
      imemaddr = 32'h44; iwait = 1'b0; iload = 32'h0000000A;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_miss: ihit=%b want 0", ihit);
      end
      @(negedge CLK); #1; vectors++;
      if (iREN !== 1'b1 || iaddr !== 32'h44 || miss_count !== 16'd2) begin
         miscompares++;
         $display("FAIL conflict_fetch: iREN=%b iaddr=%h cnt=%0d want 1 44 2",
                  iREN, iaddr, miss_count);
      end
      @(negedge CLK); #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h0000000A) begin
         miscompares++;
         $display("FAIL conflict_hit: ihit=%b load=%h want 1 0000000a", ihit, imemload);
      end
      @(negedge CLK);
      imemaddr = 32'h4; iload = 32'h8C220000;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_evict: ihit=%b want 0", ihit);
      end
      @(negedge CLK); #1; vectors++;
      if (iaddr !== 32'h4 || miss_count !== 16'd3) begin
         miscompares++;
         $display("FAIL conflict_refetch: iaddr=%h cnt=%0d want 4 3", iaddr, miss_count);
      end
      @(negedge CLK); #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h8C220000) begin
         miscompares++;
         $display("FAIL conflict_rehit: ihit=%b load=%h want 1 8c220000", ihit, imemload);
      end
   endtask

   task automatic test_redirect;
      @(negedge CLK);
      imemaddr = 32'h10; iwait = 1'b1; iload = 32'h11111111;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_miss: ihit=%b want 0", ihit);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         imemaddr = 32'h80;
         imemREN  = (k == 0) ? 1'b0 : 1'b1;
         iwait    = (k == 2) ? 1'b0 : 1'b1;
         #1; vectors++;
         if (iREN !== 1'b1 || iaddr !== 32'h10 || ihit !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_hold k%0d: iREN=%b iaddr=%h ihit=%b want 1 10 0",
                     k, iREN, iaddr, ihit);
         end
      end
      @(negedge CLK);
      iload = 32'h22222222;
      #1; vectors++;
      if (ihit !== 1'b0 || iREN !== 1'b0 || miss_count !== 16'd4) begin
         miscompares++;
         $display("FAIL redir_newmiss: ihit=%b iREN=%b cnt=%0d want 0 0 4",
                  ihit, iREN, miss_count);
      end
      @(negedge CLK); #1; vectors++;
      if (iREN !== 1'b1 || iaddr !== 32'h80 || miss_count !== 16'd5) begin
         miscompares++;
         $display("FAIL redir_fetch80: iREN=%b iaddr=%h cnt=%0d want 1 80 5",
                  iREN, iaddr, miss_count);
      end
      @(negedge CLK); #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h22222222) begin
         miscompares++;
         $display("FAIL redir_hit80: ihit=%b load=%h want 1 22222222", ihit, imemload);
      end
      @(negedge CLK);
      imemaddr = 32'h10;
      #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h11111111) begin
         miscompares++;
         $display("FAIL redir_hit10: ihit=%b load=%h want 1 11111111", ihit, imemload);
      end
   endtask

   task automatic test_flush;
      fill_line(32'h0, 32'h33333333);
      @(negedge CLK);
      imemaddr = 32'h4;
      #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h8C220000 || miss_count !== 16'd6) begin
         miscompares++;
         $display("FAIL flush_pre4: ihit=%b load=%h cnt=%0d want 1 8c220000 6",
                  ihit, imemload, miss_count);
      end
      @(negedge CLK);
      imemaddr = 32'h0; flush = 1'b1;
      #1; vectors++;
      if (ihit !== 1'b1 || imemload !== 32'h33333333) begin
         miscompares++;
         $display("FAIL flush_same_cycle: ihit=%b load=%h want 1 33333333", ihit, imemload);
      end
      @(negedge CLK);
      flush = 1'b0; iwait = 1'b0; iload = 32'h33333333;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_miss0: ihit=%b want 0", ihit);
      end
      @(negedge CLK); #1; vectors++;
      if (iREN !== 1'b1 || miss_count !== 16'd7) begin
         miscompares++;
         $display("FAIL flush_fetch0: iREN=%b cnt=%0d want 1 7", iREN, miss_count);
      end
      @(negedge CLK);
      imemaddr = 32'h4;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_miss4: ihit=%b want 0", ihit);
      end
      @(negedge CLK);
      flush = 1'b1; iload = 32'h44444444;
      #1; vectors++;
      if (iREN !== 1'b1 || iaddr !== 32'h4 || miss_count !== 16'd8) begin
         miscompares++;
         $display("FAIL flush_fetch4: iREN=%b iaddr=%h cnt=%0d want 1 4 8",
                  iREN, iaddr, miss_count);
      end
      @(negedge CLK);
      flush = 1'b0;
      #1; vectors++;
      if (ihit !== 1'b0 || imemload !== 32'h0) begin
         miscompares++;
         $display("FAIL flush_vs_fill: ihit=%b load=%h want 0 0", ihit, imemload);
      end
      @(negedge CLK);
      imemREN = 1'b0;
      #1; vectors++;
      if (iREN !== 1'b1 || miss_count !== 16'd9) begin
         miscompares++;
         $display("FAIL flush_refetch4: iREN=%b cnt=%0d want 1 9", iREN, miss_count);
      end
   endtask

   task automatic test_saturation;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h100; flush = 1'b1;
      iwait = 1'b0; iload = 32'h55555555;
      repeat (131049) @(negedge CLK);
      #1; vectors++;
      if (miss_count !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL sat_near: cnt=%h want fffe", miss_count);
      end
      repeat (2) @(negedge CLK);
      #1; vectors++;
      if (miss_count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_reach: cnt=%h want ffff", miss_count);
      end
      repeat (20) @(negedge CLK);
      #1; vectors++;
      if (miss_count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_hold: cnt=%h want ffff", miss_count);
      end
      imemREN = 1'b0; flush = 1'b0;
      @(negedge CLK);
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK); #1;
         vectors++;
         if (iREN !== 1'b0 || miss_count !== 16'hFFFF || ihit !== 1'b0) begin
            miscompares++;
            $display("FAIL idle c%0d: iREN=%b cnt=%h ihit=%b want 0 ffff 0",
                     c, iREN, miss_count, ihit);
         end
      end
   endtask

   task automatic test_reset_mid_fill;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
      #1; vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_fill_miss: ihit=%b want 0", ihit);
      end
      @(negedge CLK);
      nRST = 1'b0;
      #1; vectors++;
      if (iREN !== 1'b1 || iaddr !== 32'h200 || miss_count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL rst_fill_fetch: iREN=%b iaddr=%h cnt=%h want 1 200 ffff",
                  iREN, iaddr, miss_count);
      end
      @(negedge CLK);
      nRST = 1'b1; imemREN = 1'b0;
      #1; vectors++;
      if (iREN !== 1'b0 || iaddr !== 32'h0 || miss_count !== 16'h0) begin
         miscompares++;
         $display("FAIL rst_fill_abort: iREN=%b iaddr=%h cnt=%h want 0 0 0",
                  iREN, iaddr, miss_count);
      end
   endtask

   initial begin
      test_reset;
      test_cold_miss;
      test_conflict;
      test_redirect;
      test_flush;
      test_saturation;
      test_reset_mid_fill;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache that answers the pipeline's instruction-fetch requests on the cache side of `datapath_cache_if`. It returns `ihit`/`imemload` combinationally on a hit. On a miss it runs a single-outstanding fill transaction to the memory controller (`iREN`/`iaddr`/`iwait`/`iload`) and retires the fill into the array. It sits between the datapath's fetch port and the memory-side instruction port, and also exposes a full-invalidate input and a saturating miss counter.

## Interface

- `SETS`, default 16: number of lines; power of two, ≥2. Index width `IW = log2(SETS)`.
- `CLK  in  1`: single clock; all state updates on the rising edge.
- `nRST  in  1`: reset, synchronous, active-low, sampled on the rising edge of `CLK`.
- `imemREN  in  1`: fetch request from the datapath.
- `imemaddr  in  32`: fetch byte address. Bits [1:0] are ignored.
- `ihit  out  1`: requested word is valid on `imemload` this cycle.
- `imemload  out  32`: instruction word; 0 whenever `ihit=0`.
- `iREN  out  1`: memory read request; high only in state FETCH.
- `iaddr  out  32`: memory read address, `{miss_addr[31:2],2'b00}`.
- `iwait  in  1`: memory busy; data is valid on `iload` in the cycle where `iREN=1` and `iwait=0`.
- `iload  in  32`: memory read data.
- `flush  in  1`: invalidate all lines.
- `miss_count  out  16`: number of misses taken, saturating at 0xFFFF.

## Operation

- Address split: offset [1:0], index [IW+1:2], tag [31:IW+2].
- Per line: `valid` (1 bit), tag (30−IW bits), data (32 bits). Only `valid` is reset; the tag and data arrays are not reset.
- Hit = `imemREN` & state==IDLE & `valid[idx]` & `tag[idx]==imemaddr.tag`.
  - On a hit, `ihit=1` and `imemload=data[idx]`, both combinational, in the same cycle.
- State machine (2 states):
  - **IDLE**: if `imemREN` and not hit, then at the next edge:
    - latch `miss_addr <= imemaddr`;
    - increment `miss_count` if it is below 0xFFFF;
    - go to FETCH.
    - Otherwise stay in IDLE.
  - **FETCH**: `iREN=1`, `iaddr` comes from `miss_addr`, and `ihit=0` regardless of inputs.
    - When `iwait=0`, at that edge write `data[miss_idx] <= iload`, `tag[miss_idx] <= miss_tag`, `valid[miss_idx] <= 1`, then go to IDLE.
    - While `iwait=1`, stay in FETCH.
- Changes to `imemaddr`, or `imemREN` dropping, during FETCH do not cancel the fill. The latched line is always completed. The new address is evaluated in IDLE afterwards.
- `flush=1` at an edge clears all `valid` bits. `flush` does not change the state machine or the memory transaction.
  - If a fill completes on the same edge, flush wins: the data and tag are written, but `valid[miss_idx]` ends at 0.
- `flush` does not affect `ihit` in the cycle it is asserted (it takes effect on the next edge).
- Reset (`nRST=0` at an edge) overrides everything: state IDLE, all `valid` = 0, `miss_addr` = 0, `miss_count` = 0.
  - Reset asserted during FETCH abandons the transaction; `iREN` is 0 from the next cycle.

## Timing

- Reset values of outputs: `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`, `miss_count=0`.
- Hit latency: 0 cycles (combinational from `imemaddr`/`imemREN`).
- Miss, with the miss detected in cycle N:
  - cycle N+1: FETCH, `iREN=1`;
  - memory returns in the first cycle M ≥ N+1 with `iwait=0`;
  - cycle M+1: IDLE, the line is valid, and `ihit=1` if the same address is still requested.
  - Total miss penalty is (M−N)+1 cycles; the minimum is 2 (when `iwait=0` in N+1).
- At most one outstanding memory request. `iREN` stays high continuously from FETCH entry until the `iwait=0` cycle inclusive.
- `miss_count` updates at the IDLE→FETCH edge. It holds at 0xFFFF, with no wrap.
- A back-to-back miss to a different index after a fill re-enters FETCH no earlier than cycle M+2.

## Test plan

- **Reset**: hold `nRST=0` for 2 cycles with `imemREN=1`, `imemaddr=0x0`. Require `ihit=0`, `iREN=0`, `iaddr=0`, `miss_count=0` throughout.
- **Cold miss then hit**: `imemaddr=0x00000004`, `iwait=1` for 3 cycles then 0, `iload=0x8C220000`.
  - Require `iREN=1`, `iaddr=0x4` for 4 cycles.
  - Then `ihit=1`, `imemload=0x8C220000` in the next cycle, and `miss_count=1`.
- **Conflict miss**: fill 0x004, then request 0x044 (same index, SETS=16). Require a miss, a fill of 0x044, and `miss_count=2`; a following request to 0x004 misses again (`miss_count=3`).
- **Redirect mid-fill**: miss on 0x10; during FETCH change `imemaddr` to 0x80 and drop `imemREN` for one cycle.
  - Require `iaddr` to stay 0x10 until `iwait=0`.
  - Then a new miss on 0x80 with `iaddr=0x80`.
- **Flush**:
  - Fill 0x0 and 0x4, then pulse `flush` for 1 cycle. Require both to miss afterwards.
  - Flush on the same edge as fill completion: require that line to miss on the next request.
- **Saturation and idle**: force 65536 misses and require `miss_count=0xFFFF`. With `imemREN=0`, require `iREN=0` and no count change for 10 cycles.
